// File: rtl/ob_cmd_issuer.sv
// Single-rank-pair DRAM command issuer: turns classified requests into PRE/ACT/RD/WR
// sequences and serves refresh with PREALL/REF, honouring tRP, tRCD and tRFC.
module ob_cmd_issuer #(
  parameter int TRP  = 4,
  parameter int TRCD = 4,
  parameter int TRFC = 52
) (
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [13:0] reqRow,
  input  logic [2:0]  reqBank,
  input  logic        reqRank,
  input  logic        reqWrite,
  input  logic [2:0]  numOps,
  output logic        doOp,
  input  logic        refReq,
  input  logic        refRank,
  output logic        refAck,
  output logic        doReset,
  output logic [2:0]  cmd,
  output logic [13:0] cmdRow,
  output logic [2:0]  cmdBank,
  output logic        cmdRank
);

  typedef enum logic [3:0] {
    IDLE, CLASSIFY, PRE, WAIT_RP, ACT, WAIT_RCD, RDWR,
    RPREALL, RWAIT_RP, REF, RWAIT_RFC
  } state_t;

  localparam logic [2:0] CMD_NOP    = 3'b000;
  localparam logic [2:0] CMD_ACT    = 3'b001;
  localparam logic [2:0] CMD_RD     = 3'b010;
  localparam logic [2:0] CMD_WR     = 3'b011;
  localparam logic [2:0] CMD_PRE    = 3'b100;
  localparam logic [2:0] CMD_PREALL = 3'b101;
  localparam logic [2:0] CMD_REF    = 3'b110;

  // The issuing state occupies one cycle and the wait state exits when the
  // counter reaches zero, so the wait is loaded with (t - 2); t <= 1 skips it.
  localparam logic       SKIP_RP  = (TRP  <= 1);
  localparam logic       SKIP_RCD = (TRCD <= 1);
  localparam logic       SKIP_RFC = (TRFC <= 1);
  localparam logic [7:0] TRP_LD   = (TRP  > 1) ? 8'(TRP  - 2) : 8'd0;
  localparam logic [7:0] TRCD_LD  = (TRCD > 1) ? 8'(TRCD - 2) : 8'd0;
  localparam logic [7:0] TRFC_LD  = (TRFC > 1) ? 8'(TRFC - 2) : 8'd0;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [13:0] row_q, row_d;
  logic [2:0]  bank_q, bank_d;
  logic        rank_q, rank_d;
  logic        wr_q, wr_d;
  logic        ref_rank_q, ref_rank_d;
  logic [2:0]  cmd_q, cmd_d;
  logic [13:0] cmd_row_q, cmd_row_d;
  logic [2:0]  cmd_bank_q, cmd_bank_d;
  logic        cmd_rank_q, cmd_rank_d;
  logic        ref_ack_q, ref_ack_d;

  assign reqReady = Reset_n && (state_q == IDLE) && !refReq;
  assign doOp     = reqValid && reqReady;
  assign cmd      = cmd_q;
  assign cmdRow   = cmd_row_q;
  assign cmdBank  = cmd_bank_q;
  assign cmdRank  = cmd_rank_q;
  assign refAck   = ref_ack_q;
  assign doReset  = ref_ack_q;

  // Next-state and wait-counter logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    row_d      = row_q;
    bank_d     = bank_q;
    rank_d     = rank_q;
    wr_d       = wr_q;
    ref_rank_d = ref_rank_q;
    case (state_q)
      IDLE: begin
        if (refReq) begin
          ref_rank_d = refRank;
          state_d    = RPREALL;
        end else if (doOp) begin
          row_d   = reqRow;
          bank_d  = reqBank;
          rank_d  = reqRank;
          wr_d    = reqWrite;
          state_d = CLASSIFY;
        end
      end
      CLASSIFY: begin
        case (numOps)
          3'b001:  state_d = RDWR;
          3'b010:  state_d = ACT;
          default: state_d = PRE;
        endcase
      end
      PRE: begin
        cnt_d   = TRP_LD;
        state_d = SKIP_RP ? ACT : WAIT_RP;
      end
      WAIT_RP: begin
        if (cnt_q == 8'd0) state_d = ACT;
        else               cnt_d   = cnt_q - 8'd1;
      end
      ACT: begin
        cnt_d   = TRCD_LD;
        state_d = SKIP_RCD ? RDWR : WAIT_RCD;
      end
      WAIT_RCD: begin
        if (cnt_q == 8'd0) state_d = RDWR;
        else               cnt_d   = cnt_q - 8'd1;
      end
      RDWR: state_d = IDLE;
      RPREALL: begin
        cnt_d   = TRP_LD;
        state_d = SKIP_RP ? REF : RWAIT_RP;
      end
      RWAIT_RP: begin
        if (cnt_q == 8'd0) state_d = REF;
        else               cnt_d   = cnt_q - 8'd1;
      end
      REF: begin
        cnt_d   = TRFC_LD;
        state_d = SKIP_RFC ? IDLE : RWAIT_RFC;
      end
      RWAIT_RFC: begin
        if (cnt_q == 8'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // The command register mirrors the state being entered, so each issuing
  // state shows its command for exactly the one cycle it is occupied.
  always_comb begin
    cmd_d      = CMD_NOP;
    cmd_row_d  = cmd_row_q;
    cmd_bank_d = cmd_bank_q;
    cmd_rank_d = cmd_rank_q;
    ref_ack_d  = 1'b0;
    case (state_d)
      PRE: begin
        cmd_d      = CMD_PRE;
        cmd_bank_d = bank_q;
        cmd_rank_d = rank_q;
      end
      ACT: begin
        cmd_d      = CMD_ACT;
        cmd_row_d  = row_q;
        cmd_bank_d = bank_q;
        cmd_rank_d = rank_q;
      end
      RDWR: begin
        cmd_d      = wr_q ? CMD_WR : CMD_RD;
        cmd_row_d  = row_q;
        cmd_bank_d = bank_q;
        cmd_rank_d = rank_q;
      end
      RPREALL: begin
        cmd_d      = CMD_PREALL;
        cmd_rank_d = ref_rank_d;
      end
      REF: begin
        cmd_d      = CMD_REF;
        cmd_rank_d = ref_rank_q;
        ref_ack_d  = 1'b1;
      end
      default: cmd_d = CMD_NOP;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      row_q      <= 14'd0;
      bank_q     <= 3'd0;
      rank_q     <= 1'b0;
      wr_q       <= 1'b0;
      ref_rank_q <= 1'b0;
      cmd_q      <= CMD_NOP;
      cmd_row_q  <= 14'd0;
      cmd_bank_q <= 3'd0;
      cmd_rank_q <= 1'b0;
      ref_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      row_q      <= row_d;
      bank_q     <= bank_d;
      rank_q     <= rank_d;
      wr_q       <= wr_d;
      ref_rank_q <= ref_rank_d;
      cmd_q      <= cmd_d;
      cmd_row_q  <= cmd_row_d;
      cmd_bank_q <= cmd_bank_d;
      cmd_rank_q <= cmd_rank_d;
      ref_ack_q  <= ref_ack_d;
    end
  end

endmodule

// File: tb/tb_ob_cmd_issuer.sv
// Directed bench for ob_cmd_issuer: hit, miss, conflict, refresh, collision and
// mid-sequence reset, with expected command timing computed by hand for defaults.
module tb_ob_cmd_issuer;

  logic        CLK = 1'b0;
  logic        Reset_n;
  logic        reqValid;
  logic        reqReady;
  logic [13:0] reqRow;
  logic [2:0]  reqBank;
  logic        reqRank;
  logic        reqWrite;
  logic [2:0]  numOps;
  logic        doOp;
  logic        refReq;
  logic        refRank;
  logic        refAck;
  logic        doReset;
  logic [2:0]  cmd;
  logic [13:0] cmdRow;
  logic [2:0]  cmdBank;
  logic        cmdRank;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] NOP = 3'b000, ACT = 3'b001, RD = 3'b010, WR = 3'b011;
  localparam logic [2:0] PRE = 3'b100, PREALL = 3'b101, REFC = 3'b110;

  ob_cmd_issuer dut (
    .CLK(CLK), .Reset_n(Reset_n), .reqValid(reqValid), .reqReady(reqReady),
    .reqRow(reqRow), .reqBank(reqBank), .reqRank(reqRank), .reqWrite(reqWrite),
    .numOps(numOps), .doOp(doOp), .refReq(refReq), .refRank(refRank),
    .refAck(refAck), .doReset(doReset), .cmd(cmd), .cmdRow(cmdRow),
    .cmdBank(cmdBank), .cmdRank(cmdRank)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  // Hold for n cycles and require every cycle to be NOP.
  task automatic nop_cycles(input string tag, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (cmd !== NOP) bad++;
    end
    chk(tag, 32'(bad), 32'd0);
  endtask

  task automatic accept(input logic [13:0] row, input logic [2:0] bank,
                        input logic rank, input logic wr, input string tag);
    reqValid = 1'b1; reqRow = row; reqBank = bank; reqRank = rank; reqWrite = wr;
    #1;
    chk(tag, 32'(doOp), 32'd1);
    step();
    reqValid = 1'b0;
  endtask

  initial begin
    int n;
    Reset_n = 1'b0; reqValid = 1'b0; reqRow = '0; reqBank = '0; reqRank = 1'b0;
    reqWrite = 1'b0; numOps = 3'b000; refReq = 1'b0; refRank = 1'b0;
    step();
    step();
    chk("rst_cmd", 32'(cmd), 32'(NOP));
    chk("rst_row", 32'(cmdRow), 32'd0);
    chk("rst_refack", 32'(refAck), 32'd0);
    chk("rst_doreset", 32'(doReset), 32'd0);
    chk("rst_ready_low", 32'(reqReady), 32'd0);
    Reset_n = 1'b1;
    #1;
    chk("ready_after_rst", 32'(reqReady), 32'd1);

    // Hit: RD two cycles after doOp, nothing else issued
    accept(14'h0123, 3'd2, 1'b0, 1'b0, "hit_doop");
    numOps = 3'b001;
    chk("hit_classify_nop", 32'(cmd), 32'(NOP));
    chk("hit_classify_rdy", 32'(reqReady), 32'd0);
    step();
    chk("hit_cmd_rd", 32'(cmd), 32'(RD));
    chk("hit_bank", 32'(cmdBank), 32'd2);
    step();
    chk("hit_back_idle_nop", 32'(cmd), 32'(NOP));
    chk("hit_ready_again", 32'(reqReady), 32'd1);

    // Miss write: ACT at t+2, WR at t+6
    accept(14'h0123, 3'd2, 1'b0, 1'b1, "miss_doop");
    numOps = 3'b010;
    step();
    chk("miss_cmd_act", 32'(cmd), 32'(ACT));
    chk("miss_act_row", 32'(cmdRow), 32'h0123);
    nop_cycles("miss_trcd_nops", 3);
    step();
    chk("miss_cmd_wr", 32'(cmd), 32'(WR));
    step();

    // Conflict read: PRE t+2, ACT t+6, RD t+10
    accept(14'h2A5C, 3'd5, 1'b1, 1'b0, "conf_doop");
    numOps = 3'b100;
    step();
    chk("conf_cmd_pre", 32'(cmd), 32'(PRE));
    chk("conf_pre_bank", 32'(cmdBank), 32'd5);
    nop_cycles("conf_trp_nops", 3);
    step();
    chk("conf_cmd_act", 32'(cmd), 32'(ACT));
    chk("conf_act_row", 32'(cmdRow), 32'h2A5C);
    nop_cycles("conf_trcd_nops", 3);
    step();
    chk("conf_cmd_rd", 32'(cmd), 32'(RD));
    chk("conf_rd_rank", 32'(cmdRank), 32'd1);
    step();

    // Illegal classification behaves as conflict
    accept(14'h0001, 3'd7, 1'b0, 1'b1, "bad_doop");
    numOps = 3'b011;
    step();
    chk("bad_numops_pre", 32'(cmd), 32'(PRE));
    nop_cycles("bad_trp_nops", 3);
    step();
    chk("bad_act", 32'(cmd), 32'(ACT));
    nop_cycles("bad_trcd_nops", 3);
    step();
    chk("bad_wr", 32'(cmd), 32'(WR));
    step();

    // Refresh rank 1
    refReq = 1'b1; refRank = 1'b1;
    #1;
    chk("ref_ready_low", 32'(reqReady), 32'd0);
    step();
    chk("ref_preall", 32'(cmd), 32'(PREALL));
    chk("ref_preall_rank", 32'(cmdRank), 32'd1);
    nop_cycles("ref_trp_nops", 3);
    step();
    chk("ref_cmd_ref", 32'(cmd), 32'(REFC));
    chk("ref_ack", 32'(refAck), 32'd1);
    chk("ref_doreset", 32'(doReset), 32'd1);
    refReq = 1'b0;
    n = 0;
    for (int i = 1; i < 52; i++) begin
      step();
      if (reqReady !== 1'b0 || cmd !== NOP || refAck !== 1'b0) n++;
    end
    chk("ref_trfc_quiet", 32'(n), 32'd0);
    step();
    chk("ref_ready_at_52", 32'(reqReady), 32'd1);

    // Collision: refresh wins, request accepted on return to IDLE
    refReq = 1'b1; refRank = 1'b0;
    reqValid = 1'b1; reqRow = 14'h3FFF; reqBank = 3'd1; reqRank = 1'b0; reqWrite = 1'b0;
    #1;
    chk("coll_no_doop", 32'(doOp), 32'd0);
    step();
    chk("coll_preall", 32'(cmd), 32'(PREALL));
    for (int i = 0; i < 4; i++) step();
    chk("coll_ref", 32'(cmd), 32'(REFC));
    refReq = 1'b0;
    n = 0;
    for (int i = 0; i < 200 && doOp !== 1'b1; i++) begin
      step();
      #1;
      n++;
    end
    chk("coll_accept_delay", 32'(n), 32'd52);
    step();
    reqValid = 1'b0;
    numOps = 3'b001;
    step();
    chk("coll_rd", 32'(cmd), 32'(RD));
    chk("coll_rd_bank", 32'(cmdBank), 32'd1);
    step();

    // Reset during tRP wait of a conflict
    accept(14'h0055, 3'd3, 1'b0, 1'b0, "rstc_doop");
    numOps = 3'b100;
    step();
    chk("rstc_pre", 32'(cmd), 32'(PRE));
    step();
    Reset_n = 1'b0;
    #1;
    chk("rstc_ready_low", 32'(reqReady), 32'd0);
    step();
    chk("rstc_cmd_nop", 32'(cmd), 32'(NOP));
    chk("rstc_row_clear", 32'(cmdBank), 32'd0);
    Reset_n = 1'b1;
    #1;
    chk("rstc_ready_high", 32'(reqReady), 32'd1);
    nop_cycles("rstc_no_act", 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
